segment_display_mux: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display, sitting directly downstream of the stopwatch's four hex/BCD segment decoders. It latches the four decoded segment vectors once per frame and scans them one digit at a time onto a shared segment bus. Each digit slot starts with an anti-ghosting blanking interval and has a per-slot PWM brightness window. It produces the physical segment/anode pins and a frame-start strobe.

---
 rtl/segment_display_mux_pkg.sv | 19 +
 rtl/segment_display_mux_scan_slot_timer.sv | 58 +++++
 rtl/segment_display_mux.sv | 88 ++++++++
 tb/tb_segment_display_mux.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/segment_display_mux_pkg.sv
// Shared widths, phase encoding and helpers for the 7-segment scan driver.
package segment_display_mux_pkg;

    localparam int DIGITS    = 4;
    localparam int SEG_WIDTH = 7;

    typedef enum logic {
        PHASE_BLANK  = 1'b0,
        PHASE_ACTIVE = 1'b1
    } phase_e;

    typedef logic [0:SEG_WIDTH-1] seg_t;

    // One-hot anode select for a digit index (active-high form).
    function automatic logic [DIGITS-1:0] digit_onehot(input logic [1:0] idx);
        return DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/segment_display_mux_scan_slot_timer.sv
// Slot/digit/PWM timebase for the display scan. All outputs are decoded
// from the current counter state; the top registers whatever it derives.
module scan_slot_timer
    import segment_display_mux_pkg::*;
#(
    parameter int SCAN_PERIOD  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [1:0] digit_idx,
    output phase_e     phase,
    output logic [3:0] pwm_cnt,
    output logic       frame_latch
);

    localparam int             CW        = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CW-1:0]  SLOT_LAST = CW'(SCAN_PERIOD - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [3:0]    pwm_cnt_q, pwm_cnt_d;
    logic          slot_wrap;

    // Next-state for slot/digit/PWM counters and decoded phase/latch strobe.
    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        phase       = (slot_cnt_q < BLANK_END) ? PHASE_BLANK : PHASE_ACTIVE;
        // PWM restarts at 0 on the first ACTIVE cycle of every slot,
        // otherwise free-runs mod 16 through the ACTIVE window.
        pwm_cnt_d   = pwm_cnt_q;
        if (slot_cnt_d == BLANK_END)
            pwm_cnt_d = 4'd0;
        else if (phase == PHASE_ACTIVE)
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        frame_latch = (slot_cnt_q == '0) && (digit_idx_q == 2'd0);
    end

    // Counter registers; reset restarts scanning at digit 0, slot start.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            pwm_cnt_q   <= 4'd0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign digit_idx = digit_idx_q;
    assign pwm_cnt   = pwm_cnt_q;

endmodule

// File: rtl/segment_display_mux.sv
// 4-digit multiplexed 7-segment driver: frame-latched segment bank,
// per-slot blanking and PWM dimming, registered pins.
module segment_display_mux
    import segment_display_mux_pkg::*;
#(
    parameter int SCAN_PERIOD      = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [0:SEG_WIDTH-1] Seg3,
    input  logic [0:SEG_WIDTH-1] Seg2,
    input  logic [0:SEG_WIDTH-1] Seg1,
    input  logic [0:SEG_WIDTH-1] Seg0,
    input  logic [DIGITS-1:0]    DigitEnable,
    input  logic [3:0]           Brightness,
    output logic [0:SEG_WIDTH-1] SegOut,
    output logic [DIGITS-1:0]    AnodeOut,
    output logic [1:0]           DigitIndex,
    output logic                 FrameTick
);

    localparam logic [0:SEG_WIDTH-1] SEG_OFF   = {SEG_WIDTH{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0]    ANODE_OFF = {DIGITS{ANODE_ACTIVE_LOW}};

    logic [1:0] digit_idx;
    phase_e     phase;
    logic [3:0] pwm_cnt;
    logic       frame_latch;

    scan_slot_timer #(
        .SCAN_PERIOD (SCAN_PERIOD),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .digit_idx  (digit_idx),
        .phase      (phase),
        .pwm_cnt    (pwm_cnt),
        .frame_latch(frame_latch)
    );

    logic [DIGITS-1:0][0:SEG_WIDTH-1] seg_in;
    logic [DIGITS-1:0][0:SEG_WIDTH-1] bank_q, bank_d;
    logic [0:SEG_WIDTH-1]             seg_out_q, seg_out_d;
    logic [DIGITS-1:0]                anode_q, anode_d;
    logic [1:0]                       digit_index_q;
    logic                             frame_tick_q;
    logic                             lit;
    seg_t                             disp;

    assign seg_in = {Seg3, Seg2, Seg1, Seg0};

    // Bank update and output mux. The mux reads the next bank value so a
    // digit lit on the latch cycle shows the freshly sampled segments.
    always_comb begin
        bank_d    = frame_latch ? seg_in : bank_q;
        lit       = (phase == PHASE_ACTIVE) && DigitEnable[digit_idx] && (pwm_cnt < Brightness);
        disp      = bank_d[digit_idx];
        seg_out_d = (lit ? disp : '0) ^ SEG_OFF;
        anode_d   = (lit ? digit_onehot(digit_idx) : '0) ^ ANODE_OFF;
    end

    // Output and bank registers; reset forces dark pins immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bank_q        <= '0;
            seg_out_q     <= SEG_OFF;
            anode_q       <= ANODE_OFF;
            digit_index_q <= 2'd0;
            frame_tick_q  <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            seg_out_q     <= seg_out_d;
            anode_q       <= anode_d;
            digit_index_q <= digit_idx;
            frame_tick_q  <= frame_latch;
        end
    end

    assign SegOut     = seg_out_q;
    assign AnodeOut   = anode_q;
    assign DigitIndex = digit_index_q;
    assign FrameTick  = frame_tick_q;

endmodule

// File: tb/tb_segment_display_mux.sv
// Randomized self-checking bench for segment_display_mux with a
// cycle-count based reference model (SCAN_PERIOD=8, BLANK_CYCLES=2).
module tb_segment_display_mux;

    localparam int SP = 8;
    localparam int BL = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [0:6] seg_in [4];
    logic [3:0] en = 4'h0;
    logic [3:0] bright = 4'h0;
    logic [0:6] SegOut;
    logic [3:0] AnodeOut;
    logic [1:0] DigitIndex;
    logic       FrameTick;

    int checks = 0;
    int errors = 0;

    // model state: n = clock edges since reset release
    int         n = 0;
    logic [0:6] mbank [4];
    logic [3:0] exp_anode;
    logic [0:6] exp_seg;
    logic [1:0] exp_idx;
    logic       exp_tick;

    always #5 Clk = ~Clk;

    segment_display_mux #(
        .SCAN_PERIOD(SP), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Seg3(seg_in[3]), .Seg2(seg_in[2]), .Seg1(seg_in[1]), .Seg0(seg_in[0]),
        .DigitEnable(en), .Brightness(bright),
        .SegOut(SegOut), .AnodeOut(AnodeOut), .DigitIndex(DigitIndex), .FrameTick(FrameTick)
    );

    // Advance one clock; predict the registered outputs from the edge index.
    task automatic tick();
        int digit, slot, pos;
        logic lit;
        logic [3:0] sel;
        @(posedge Clk);
        pos   = n % (4 * SP);
        slot  = n % SP;
        digit = (n / SP) % 4;
        if (pos == 0) for (int d = 0; d < 4; d++) mbank[d] = seg_in[d];
        lit = (slot >= BL) && en[digit] && (((slot - BL) % 16) < int'(bright));
        sel = 4'b0001 << digit;
        exp_anode = lit ? ~sel : 4'hF;
        exp_seg   = lit ? ~mbank[digit] : 7'h7F;
        exp_idx   = 2'(digit);
        exp_tick  = (pos == 0);
        n++;
        @(negedge Clk);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b1;
        n = 0;
        for (int d = 0; d < 4; d++) mbank[d] = 7'h00;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        checks++;
        if (AnodeOut !== 4'hF) begin errors++; $display("FAIL reset_anode: got %b want 1111", AnodeOut); end
        checks++;
        if (SegOut !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b want 1111111", SegOut); end
        checks++;
        if (DigitIndex !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", DigitIndex); end
        checks++;
        if (FrameTick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", FrameTick); end
    endtask

    task automatic test_basic();
        int ticks = 0;
        seg_in[0] = 7'b1000000; seg_in[1] = 7'b0100000;
        seg_in[2] = 7'b0010000; seg_in[3] = 7'b0001000;
        bright = 4'd15; en = 4'hF;
        release_reset();
        repeat (64) begin
            tick();
            if (FrameTick) ticks++;
            checks++;
            if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {exp_anode, exp_seg, exp_idx, exp_tick}) begin
                errors++;
                $display("FAIL basic n=%0d: anode=%b seg=%b idx=%0d tick=%b want anode=%b seg=%b idx=%0d tick=%b",
                         n-1, AnodeOut, SegOut, DigitIndex, FrameTick, exp_anode, exp_seg, exp_idx, exp_tick);
            end
        end
        checks++;
        if (ticks != 2) begin errors++; $display("FAIL basic_tick_count: got %0d want 2", ticks); end
    endtask

    task automatic test_mid_frame_change();
        int old_seen = 0;
        int new_seen = 0;
        logic [0:6] old_v, new_v;
        old_v = seg_in[2];
        new_v = 7'b0000011;
        repeat (64) begin
            if ((n % 32) == 12 && seg_in[2] == old_v) seg_in[2] = new_v;
            tick();
            if (AnodeOut == 4'b1011 && SegOut == ~old_v) old_seen++;
            if (AnodeOut == 4'b1011 && SegOut == ~new_v) new_seen++;
            checks++;
            if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {exp_anode, exp_seg, exp_idx, exp_tick}) begin
                errors++;
                $display("FAIL midframe n=%0d: anode=%b seg=%b idx=%0d tick=%b want anode=%b seg=%b idx=%0d tick=%b",
                         n-1, AnodeOut, SegOut, DigitIndex, FrameTick, exp_anode, exp_seg, exp_idx, exp_tick);
            end
        end
        checks++;
        if (old_seen != 6 || new_seen != 6) begin
            errors++;
            $display("FAIL midframe_digit2: old=%0d new=%0d want 6 and 6", old_seen, new_seen);
        end
    endtask

    task automatic test_enable();
        int last_tick = -1;
        int bad_anode = 0;
        en = 4'b0101;
        repeat (96) begin
            tick();
            if (AnodeOut[1] == 1'b0 || AnodeOut[3] == 1'b0) bad_anode++;
            if (FrameTick) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (n - last_tick != 32) begin errors++; $display("FAIL enable_tick_period: got %0d want 32", n - last_tick); end
                end
                last_tick = n;
            end
            checks++;
            if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {exp_anode, exp_seg, exp_idx, exp_tick}) begin
                errors++;
                $display("FAIL enable n=%0d: anode=%b seg=%b want anode=%b seg=%b", n-1, AnodeOut, SegOut, exp_anode, exp_seg);
            end
        end
        checks++;
        if (bad_anode != 0) begin errors++; $display("FAIL enable_masked: got %0d lit cycles on digits 1/3 want 0", bad_anode); end
        en = 4'hF;
    endtask

    task automatic test_brightness();
        int lit_cnt;
        for (int b = 0; b < 2; b++) begin
            bright = (b == 0) ? 4'd3 : 4'd0;
            tick();  // one cycle for the new duty to reach the pins
            lit_cnt = 0;
            repeat (64) begin
                tick();
                if (AnodeOut != 4'hF) lit_cnt++;
                checks++;
                if ({AnodeOut, SegOut} !== {exp_anode, exp_seg}) begin
                    errors++;
                    $display("FAIL bright%0d n=%0d: anode=%b seg=%b want anode=%b seg=%b",
                             bright, n-1, AnodeOut, SegOut, exp_anode, exp_seg);
                end
            end
            checks++;
            if (lit_cnt != ((b == 0) ? 24 : 0)) begin
                errors++;
                $display("FAIL bright_lit_count b=%0d: got %0d want %0d", bright, lit_cnt, (b == 0) ? 24 : 0);
            end
        end
        bright = 4'd15;
    endtask

    task automatic test_random();
        repeat (400) begin
            for (int d = 0; d < 4; d++) seg_in[d] = 7'($urandom);
            if ($urandom_range(0, 7) == 0) en = 4'($urandom);
            if ($urandom_range(0, 7) == 0) bright = 4'($urandom);
            tick();
            checks++;
            if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {exp_anode, exp_seg, exp_idx, exp_tick}) begin
                errors++;
                $display("FAIL random n=%0d: anode=%b seg=%b idx=%0d tick=%b want anode=%b seg=%b idx=%0d tick=%b",
                         n-1, AnodeOut, SegOut, DigitIndex, FrameTick, exp_anode, exp_seg, exp_idx, exp_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        int first_lit = -1;
        en = 4'hF; bright = 4'd15;
        while (((n - 1) % 32) != 20 && guard < 64) begin tick(); guard++; end
        checks++;
        if (AnodeOut !== 4'b1011) begin errors++; $display("FAIL areset_pre: anode=%b want 1011", AnodeOut); end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL areset_immediate: anode=%b seg=%b idx=%0d tick=%b want 1111 1111111 0 0",
                     AnodeOut, SegOut, DigitIndex, FrameTick);
        end
        seg_in[0] = 7'b1110001; seg_in[1] = 7'b0001110;
        seg_in[2] = 7'b1010101; seg_in[3] = 7'b0101010;
        release_reset();
        repeat (40) begin
            tick();
            if (first_lit < 0 && AnodeOut != 4'hF) first_lit = n - 1;
            checks++;
            if ({AnodeOut, SegOut, DigitIndex, FrameTick} !== {exp_anode, exp_seg, exp_idx, exp_tick}) begin
                errors++;
                $display("FAIL areset_resume n=%0d: anode=%b seg=%b idx=%0d tick=%b want anode=%b seg=%b idx=%0d tick=%b",
                         n-1, AnodeOut, SegOut, DigitIndex, FrameTick, exp_anode, exp_seg, exp_idx, exp_tick);
            end
        end
        checks++;
        if (first_lit != 2) begin errors++; $display("FAIL areset_first_lit: got edge %0d want 2", first_lit); end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin seg_in[d] = 7'h00; mbank[d] = 7'h00; end
        test_reset();
        test_basic();
        test_mid_frame_change();
        test_enable();
        test_brightness();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
